// File: rtl/csa_addsub_pipe_if.sv
// Operand/result handshake bundle for csa_addsub_pipe.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface csa_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             zero_flag;
    logic             neg_flag;
    logic             cout;
    logic             ovf_flag;

    modport master (
        output in_valid, a, b, cin, sub, sat, out_ready,
        input  in_ready, out_valid, sum, zero_flag, neg_flag, cout, ovf_flag
    );

    modport slave (
        input  in_valid, a, b, cin, sub, sat, out_ready,
        output in_ready, out_valid, sum, zero_flag, neg_flag, cout, ovf_flag
    );
endinterface

// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor, one carry-select block per stage, with ALU flags.
// Define CSA_SAT_EN to enable signed saturation on request (sat input).
module csa_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    csa_addsub_pipe_if.slave  bus
);
    localparam int NB = WIDTH / BLOCK;
    localparam int NR = (NB > 1) ? NB - 1 : 1;

`ifdef CSA_SAT_EN
    function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] raw,
                                                   input logic ovf, input logic en);
        logic [WIDTH-1:0] res;
        res = raw;
        // A wrapped-negative raw result means the true value overflowed upwards.
        if (en && ovf) begin
            res = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
        return res;
    endfunction
`endif

    logic adv;

    // Stage inputs (from the ports for stage 0, else from the previous stage register)
    logic [WIDTH-1:0] stg_a [NB];
    logic [WIDTH-1:0] stg_b [NB];
    logic [WIDTH-1:0] stg_r [NB];
    logic             stg_c [NB];
    logic             stg_v [NB];
    logic [WIDTH-1:0] res_d [NB];
    logic             c_d   [NB];

    // Inter-stage registers
    logic [WIDTH-1:0] a_q [NR];
    logic [WIDTH-1:0] b_q [NR];
    logic [WIDTH-1:0] r_q [NR];
    logic             c_q [NR];
    logic [NR-1:0]    vld_q;

`ifdef CSA_SAT_EN
    logic             stg_s [NB];
    logic             sat_q [NR];
`else
    logic             unused_sat;
    assign unused_sat = bus.sat;
`endif

    // Output register
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             zero_q, neg_q, cout_q, ovf_q;
    logic             zero_d, neg_d, cout_d, ovf_d;
    logic [WIDTH-1:0] raw_sum;
    logic             c_msb;

    assign adv          = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < NB; k++) begin : g_stage
        logic [BLOCK-1:0] blk_a, blk_b, blk_sum;

        if (k == 0) begin : g_src
            assign stg_a[0] = bus.a;
            assign stg_b[0] = bus.b ^ {WIDTH{bus.sub}};
            assign stg_r[0] = '0;
            assign stg_c[0] = bus.sub | bus.cin;
            assign stg_v[0] = bus.in_valid;
`ifdef CSA_SAT_EN
            assign stg_s[0] = bus.sat;
`endif
        end else begin : g_src
            assign stg_a[k] = a_q[k-1];
            assign stg_b[k] = b_q[k-1];
            assign stg_r[k] = r_q[k-1];
            assign stg_c[k] = c_q[k-1];
            assign stg_v[k] = vld_q[k-1];
`ifdef CSA_SAT_EN
            assign stg_s[k] = sat_q[k-1];
`endif
        end

        assign blk_a = stg_a[k][k*BLOCK +: BLOCK];
        assign blk_b = stg_b[k][k*BLOCK +: BLOCK];

        if (k == 0) begin : g_add
            // Block 0 sees the effective carry-in directly, so a plain ripple add suffices.
            logic [BLOCK:0] rc;
            assign rc      = {1'b0, blk_a} + {1'b0, blk_b} + {{BLOCK{1'b0}}, stg_c[0]};
            assign blk_sum = rc[BLOCK-1:0];
            assign c_d[0]  = rc[BLOCK];
        end else begin : g_add
            logic [BLOCK:0] s0, s1;
            assign s0      = {1'b0, blk_a} + {1'b0, blk_b};
            assign s1      = {1'b0, blk_a} + {1'b0, blk_b} + (BLOCK+1)'(1);
            assign blk_sum = stg_c[k] ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
            assign c_d[k]  = s0[BLOCK] | (s1[BLOCK] & stg_c[k]);
        end

        // Resolved bits above this block are still zero, so OR-ing in the block is enough.
        assign res_d[k] = stg_r[k] | (WIDTH'(blk_sum) << (k*BLOCK));
    end

    // Final stage: flags from the resolved carries
    assign raw_sum = res_d[NB-1];
    assign cout_d  = c_d[NB-1];
    assign c_msb   = stg_a[NB-1][WIDTH-1] ^ stg_b[NB-1][WIDTH-1] ^ raw_sum[WIDTH-1];
    assign ovf_d   = c_msb ^ cout_d;
`ifdef CSA_SAT_EN
    assign sum_d   = sat_clamp(raw_sum, ovf_d, stg_s[NB-1]);
`else
    assign sum_d   = raw_sum;
`endif
    assign zero_d  = (sum_d == '0);
    assign neg_d   = sum_d[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NB - 1; k++) begin
                vld_q[k] <= stg_v[k];
            end
            out_valid_q <= stg_v[NB-1];
            // Bubbles leave the last delivered result on the outputs.
            if (stg_v[NB-1]) begin
                sum_q  <= sum_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < NB - 1; k++) begin
                a_q[k] <= stg_a[k];
                b_q[k] <= stg_b[k];
                r_q[k] <= res_d[k];
                c_q[k] <= c_d[k];
`ifdef CSA_SAT_EN
                sat_q[k] <= stg_s[k];
`endif
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.zero_flag = zero_q;
    assign bus.neg_flag  = neg_q;
    assign bus.cout      = cout_q;
    assign bus.ovf_flag  = ovf_q;
endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Randomized and directed bench for csa_addsub_pipe against an arithmetic reference model.
module tb_csa_addsub_pipe;
    localparam int W  = 32;
    localparam int NB = 4;
    localparam longint MAXS = (longint'(1) << (W-1)) - 1;
    localparam longint MINS = -(longint'(1) << (W-1));

    typedef struct packed {
        logic [W-1:0] sum;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;
    int   nrecv = 0;
    exp_t q [$];

    csa_addsub_pipe_if #(.WIDTH(W)) bus ();

    csa_addsub_pipe #(.WIDTH(W), .BLOCK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic sat);
        exp_t   e;
        longint sa, sb, sr, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            sr    = sa - sb;
            e.c   = (ua >= ub);
            e.sum = a - b;
        end else begin
            sr    = sa + sb + longint'(cin);
            e.c   = ((ua + ub + longint'(cin)) >= (longint'(1) << W));
            e.sum = a + b + W'(cin);
        end
        e.v = (sr > MAXS) || (sr < MINS);
`ifdef CSA_SAT_EN
        if (sat && e.v) e.sum = (sr > 0) ? W'(MAXS) : W'(MINS);
`else
        if (sat) e.sum = e.sum;
`endif
        e.z = (e.sum == '0);
        e.n = e.sum[W-1];
        return e;
    endfunction

    // One clock: score outputs against the model queue, record acceptance, advance.
    task automatic tick(output logic acc);
        exp_t e;
        #1;
        acc = rst_n && bus.in_valid && bus.in_ready;
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'(0));
            end else begin
                e = q[0];
                chk("sum",  64'(bus.sum),       64'(e.sum));
                chk("zero", 64'(bus.zero_flag), 64'(e.z));
                chk("neg",  64'(bus.neg_flag),  64'(e.n));
                chk("cout", 64'(bus.cout),      64'(e.c));
                chk("ovf",  64'(bus.ovf_flag),  64'(e.v));
                if (rst_n && bus.out_ready) begin
                    void'(q.pop_front());
                    nrecv++;
                end
            end
        end
        if (acc) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.sat));
        if (!rst_n) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic sat);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.sat      = sat;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic sat,
                            input logic [W-1:0] xs, input logic xz, input logic xn,
                            input logic xc, input logic xv);
        logic acc;
        int   n;
        bus.out_ready = 1'b1;
        drive(1'b1, a, b, cin, sub, sat);
        tick(acc);
        chk({tag, "_accept"}, 64'(acc), 64'(1));
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick(acc);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(NB - 1));
        chk({tag, "_sum"},  64'(bus.sum),       64'(xs));
        chk({tag, "_zero"}, 64'(bus.zero_flag), 64'(xz));
        chk({tag, "_neg"},  64'(bus.neg_flag),  64'(xn));
        chk({tag, "_cout"}, 64'(bus.cout),      64'(xc));
        chk({tag, "_ovf"},  64'(bus.ovf_flag),  64'(xv));
        tick(acc);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic acc;
        int   i, stall, guard, base;

        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(acc);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_sum",       64'(bus.sum),       64'(0));
        chk("rst_flags",     64'({bus.zero_flag, bus.neg_flag, bus.cout, bus.ovf_flag}), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        @(negedge clk);

        directed("add",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 0, 0, 0, 0);
        directed("wrap",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
        directed("ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
`ifdef CSA_SAT_EN
        directed("sat",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 0, 0, 0, 1);
        directed("satn",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 0, 1, 1, 1);
`else
        directed("nosat", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 0, 1, 0, 1);
`endif
        directed("sub57", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 0, 1, 0, 0);
        directed("sub75", 32'd7, 32'd5, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 0, 0, 1, 0);
        directed("subov", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 0, 0, 1, 1);

        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, pick(), pick(),
                  1'($urandom), 1'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (NB + 2) tick(acc);
        chk("rand_drained", 64'(q.size()), 64'(0));

        i = 1; stall = -1; guard = 0; base = nrecv;
        while ((nrecv - base) < 8 && guard < 200) begin
            drive(i <= 8, W'(i), W'(i), 1'b0, 1'b0, 1'b0);
            if (stall < 0 && bus.out_valid === 1'b1) stall = 3;
            bus.out_ready = (stall > 0) ? 1'b0 : 1'b1;
            if (stall > 0) begin
                #1;
                chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            end
            tick(acc);
            if (acc) i++;
            if (stall > 0) stall--;
            guard++;
        end
        chk("bp_received", 64'(nrecv - base), 64'(8));
        chk("bp_accepted", 64'(i - 1), 64'(8));
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (NB + 2) tick(acc);
        chk("bp_drained", 64'(q.size()), 64'(0));

        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, W'(k * 100), W'(k), 1'b0, 1'b0, 1'b0);
            tick(acc);
        end
        rst_n = 1'b0;
        drive(1'b1, 32'h0000_0042, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        tick(acc);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_sum",   64'(bus.sum),       64'(0));
        chk("mid_rst_flags", 64'({bus.zero_flag, bus.neg_flag, bus.cout, bus.ovf_flag}), 64'(0));
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (8) tick(acc);
        chk("mid_rst_nothing", 64'(q.size()), 64'(0));
        directed("post_rst", 32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 1'b0, 32'h0000_2345, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/csa_addsub_pipe.md
# csa_addsub_pipe

Pipelined, parametrised carry-select adder/subtractor with a valid/ready handshake and a full ALU flag set. It is the successor to the fixed 32-bit combinational carry-select adder. The datapath is split into `WIDTH/BLOCK` carry-select blocks, with one pipeline stage per block. Results issue in order to a downstream consumer, one operation per cycle, with full backpressure.

## Interface
- `WIDTH`, default 32: operand width. Must be an integer multiple of `BLOCK`, and at least `BLOCK`.
- `BLOCK`, default 8: bits per carry-select block. `NB = WIDTH/BLOCK` stages.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: operation present on `a`/`b`/`cin`/`sub`/`sat`.
- `in_ready` output 1: block accepts the operation this cycle.
- `a`, `b` input `WIDTH`: operands, two's complement.
- `cin` input 1: carry-in, used only when `sub`=0.
- `sub` input 1: 1 selects `a + ~b + 1`; `cin` is ignored.
- `sat` input 1: request signed saturation. Ignored unless `CSA_SAT_EN` is defined.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `sum` output `WIDTH`: result.
- `zero_flag` output 1: `sum == 0`, evaluated after saturation.
- `neg_flag` output 1: `sum[WIDTH-1]`.
- `cout` output 1: carry out of the MSB. For subtraction this is no-borrow: 1 iff `a >= b` unsigned.
- `ovf_flag` output 1: signed overflow, equal to carry into the MSB XOR carry out of the MSB. Reports the raw overflow even when the result is saturated.

## Operation
- Stage 0 registers the operands after `b` is conditionally inverted. It resolves block 0 with a ripple-carry adder using the effective carry-in (`sub` ? 1 : `cin`).
- Stage k (1..NB-1) holds two precomputed sums for block k, one for carry-in 0 and one for carry-in 1, together with their carry-outs. It selects between them using the registered carry from stage k-1.
  - The block carry-out is `c0 | (c1 & carry_in)`.
  - Each stage carries forward the already-resolved low bits, the not-yet-resolved high operand bits, the running carry, and the carry into the MSB.
- Output register (stage NB-1): `sum`, all flags, `out_valid`.
- Flags are computed in the final stage from the resolved carries. `zero_flag` and `neg_flag` are derived from the final `sum`.
- Each stage has one valid bit. The whole pipeline advances when `adv = ~out_valid | out_ready`; on `adv`, valid bits shift by one stage.
- `in_ready = adv`, combinational. An operation is accepted when `in_valid & in_ready`.
- While `adv`=0, no register changes, including data, valids, and the output. Outputs stay stable under backpressure.
- Bubbles propagate as invalid stages. Data registers of invalid stages are don't-care, except the output register, which holds its last value.
- Results emerge in acceptance order. There is no reordering and nothing is dropped.

## Timing
- Latency: `NB` cycles. An operation accepted at edge t gives `out_valid`=1 after edge t+NB-1 if no stall occurs. For the defaults that is 4 cycles, counting the acceptance edge as cycle 1.
- Throughput: 1 operation per cycle when `out_ready`=1.
- Reset (`rst_n`=0 at a rising edge):
  - All stage valid bits clear, and `out_valid` becomes 0.
  - `sum`, `zero_flag`, `neg_flag`, `cout` and `ovf_flag` become 0.
  - In-flight operations are discarded.
  - An `in_valid` sampled on the reset edge is not accepted.
  - On the first edge after `rst_n` returns to 1, `in_ready`=1.
- Simultaneous output handshake and new input: both complete in the same cycle with no bubble.
- Backpressure: a stall freezes all NB stages. At most NB operations are ever held.
- `NB`=1: this is a single registered ripple-carry adder, and latency is 1.

## Configuration
- `CSA_SAT_EN` defined: when `sat`=1 and a signed overflow occurs, `sum` clamps.
  - Positive overflow gives `{1'b0,{WIDTH-1{1'b1}}}`; negative overflow gives `{1'b1,{WIDTH-1{1'b0}}}`.
  - `ovf_flag` is still 1, and `cout` is unchanged.
  - `sat` is pipelined alongside its operation.
- `CSA_SAT_EN` undefined: `sat` is unused, `sum` always wraps modulo 2^WIDTH, and no saturation logic is present.

## Test plan
All scenarios use the defaults (WIDTH=32, BLOCK=8).
- Basic add: `a`=0x0000_00FF, `b`=0x0000_0001, `cin`=0, `sub`=0 -> 4 cycles later `sum`=0x0000_0100, `cout`=0, `zero_flag`=0, `ovf_flag`=0.
- Carry wraps through all blocks: 0xFFFF_FFFF + 0x0000_0000 with `cin`=1 -> `sum`=0, `zero_flag`=1, `cout`=1, `ovf_flag`=0.
- Signed overflow: 0x7FFF_FFFF + 1 -> `sum`=0x8000_0000, `ovf_flag`=1, `neg_flag`=1.
  - With `CSA_SAT_EN` and `sat`=1 -> `sum`=0x7FFF_FFFF, `ovf_flag`=1, `neg_flag`=0.
- Subtract: 5 - 7 with `sub`=1 and `cin`=1 (ignored) -> `sum`=0xFFFF_FFFE, `cout`=0, `neg_flag`=1. Then 7 - 5 -> `sum`=2, `cout`=1.
- Backpressure: issue 8 back-to-back operations (i + i for i = 1..8) with `out_ready`=0 from the first `out_valid` for 3 cycles -> `in_ready` is 0 during the stall, outputs stay stable, and results 2, 4, ..., 16 arrive in order with none lost or duplicated.
- Reset mid-flight: accept 3 operations, then assert `rst_n`=0 for 1 cycle -> `out_valid`=0 and all outputs are 0 next cycle, none of the 3 results ever appear, and a new operation after reset returns after 4 cycles.
